bp_clint_cmd_arbiter: RTL and testbench

//  Shares the single CLINT mem_cmd/mem_resp port between num_req_p requesters (I/O link client,

---
 rtl/bp_clint_cmd_arbiter_pkg.sv | 9 +
 rtl/bp_clint_tag_fifo.sv | 53 +++++
 rtl/bp_clint_cmd_arbiter.sv | 102 ++++++++++
 tb/tb_bp_clint_cmd_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/bp_clint_cmd_arbiter_pkg.sv
// Shared helpers for the CLINT command arbiter slice.
package bp_clint_cmd_arbiter_pkg;

  // Width of an index into n items; never returns zero so single-entry cases stay legal.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bp_clint_tag_fifo.sv
// In-order source-tag FIFO: remembers which requester issued each outstanding CLINT command.
module bp_clint_tag_fifo
  import bp_clint_cmd_arbiter_pkg::*;
#(
  parameter int els_p       = 2,
  parameter int tag_width_p = 1
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   push_i,
  input  logic [tag_width_p-1:0] data_i,
  input  logic                   pop_i,
  output logic [tag_width_p-1:0] data_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int ptr_w = safe_clog2(els_p);
  localparam int cnt_w = $clog2(els_p + 1);

  logic [els_p-1:0][tag_width_p-1:0] mem;
  logic [ptr_w-1:0]                  rptr, wptr;
  logic [cnt_w-1:0]                  count;

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (32'(p) == els_p - 1) ? '0 : p + ptr_w'(1);
  endfunction

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      mem   <= '0;
    end else begin
      if (push_i) begin
        mem[wptr] <= data_i;
        wptr      <= ptr_inc(wptr);
      end
      if (pop_i)
        rptr <= ptr_inc(rptr);
      if (push_i && !pop_i)
        count <= count + cnt_w'(1);
      else if (pop_i && !push_i)
        count <= count - cnt_w'(1);
    end
  end

  assign data_o  = mem[rptr];
  assign full_o  = (count == cnt_w'(els_p));
  assign empty_o = (count == '0);

endmodule

// File: rtl/bp_clint_cmd_arbiter.sv
// Round-robin sharing of the CLINT command port, with in-order routing of responses to issuers.
module bp_clint_cmd_arbiter
  import bp_clint_cmd_arbiter_pkg::*;
#(
  parameter int num_req_p    = 2,
  parameter int cmd_width_p  = 8,
  parameter int resp_width_p = 8,
  parameter int els_p        = 2
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [num_req_p*cmd_width_p-1:0] req_cmd_i,
  input  logic [num_req_p-1:0]             req_cmd_v_i,
  output logic [num_req_p-1:0]             req_cmd_yumi_o,
  output logic [resp_width_p-1:0]          req_resp_o,
  output logic [num_req_p-1:0]             req_resp_v_o,
  input  logic [num_req_p-1:0]             req_resp_ready_i,
  output logic [cmd_width_p-1:0]           cmd_o,
  output logic                             cmd_v_o,
  input  logic                             cmd_yumi_i,
  input  logic [resp_width_p-1:0]          resp_i,
  input  logic                             resp_v_i,
  output logic                             resp_ready_o
);

  localparam int tag_w = safe_clog2(num_req_p);
  typedef logic [tag_w-1:0] tag_t;

  logic [num_req_p-1:0][cmd_width_p-1:0] cmd_arr;
  tag_t rr_ptr, winner, head, owner;
  logic found, full, empty, grant, owner_valid, resp_fire, bypass, push, pop;

  assign cmd_arr = req_cmd_i;

  // Two passes: at/above the pointer first, then wrap to the lowest index below it.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      if (!found && req_cmd_v_i[i] && (i >= 32'(rr_ptr))) begin
        winner = tag_t'(i);
        found  = 1'b1;
      end
    end
    for (int unsigned i = 0; i < num_req_p; i++) begin
      if (!found && req_cmd_v_i[i]) begin
        winner = tag_t'(i);
        found  = 1'b1;
      end
    end
  end

  assign cmd_v_o = found & ~full & reset_n_i;
  assign cmd_o   = cmd_arr[winner];
  assign grant   = cmd_yumi_i & cmd_v_o;

  // With nothing outstanding, the CLINT may answer in the very cycle it takes the command.
  assign owner_valid  = ~empty | grant;
  assign owner        = empty ? winner : head;
  assign resp_ready_o = req_resp_ready_i[owner] & owner_valid & reset_n_i;
  assign req_resp_o   = resp_i;
  assign resp_fire    = resp_v_i & resp_ready_o;
  assign bypass       = empty & grant & resp_fire;
  assign push         = grant & ~bypass;
  assign pop          = ~empty & resp_fire;

  always_comb begin
    req_cmd_yumi_o = '0;
    req_resp_v_o   = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      req_cmd_yumi_o[i] = grant & (32'(winner) == i);
      req_resp_v_o[i]   = resp_v_i & owner_valid & reset_n_i & (32'(owner) == i);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      rr_ptr <= '0;
    else if (grant)
      rr_ptr <= (32'(winner) == num_req_p - 1) ? '0 : winner + tag_t'(1);
  end

  bp_clint_tag_fifo #(
    .els_p       (els_p),
    .tag_width_p (tag_w)
  ) tag_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (push),
    .data_i    (winner),
    .pop_i     (pop),
    .data_o    (head),
    .full_o    (full),
    .empty_o   (empty)
  );

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    cmd_yumi_i |-> cmd_v_o);
  a_resp_has_owner: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    resp_v_i |-> (!empty || cmd_yumi_i));

endmodule

// File: tb/tb_bp_clint_cmd_arbiter.sv
// Randomized and directed checks of the CLINT command arbiter against a queue-based reference.
module tb_bp_clint_cmd_arbiter;

  localparam int N   = 2;
  localparam int CW  = 8;
  localparam int RW  = 8;
  localparam int ELS = 2;

  logic            clk_i = 1'b0;
  logic            reset_n_i;
  logic [N*CW-1:0] req_cmd_i;
  logic [N-1:0]    req_cmd_v_i;
  logic [N-1:0]    req_cmd_yumi_o;
  logic [RW-1:0]   req_resp_o;
  logic [N-1:0]    req_resp_v_o;
  logic [N-1:0]    req_resp_ready_i;
  logic [CW-1:0]   cmd_o;
  logic            cmd_v_o;
  logic            cmd_yumi_i;
  logic [RW-1:0]   resp_i;
  logic            resp_v_i;
  logic            resp_ready_o;

  bp_clint_cmd_arbiter #(
    .num_req_p    (N),
    .cmd_width_p  (CW),
    .resp_width_p (RW),
    .els_p        (ELS)
  ) dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .req_cmd_i        (req_cmd_i),
    .req_cmd_v_i      (req_cmd_v_i),
    .req_cmd_yumi_o   (req_cmd_yumi_o),
    .req_resp_o       (req_resp_o),
    .req_resp_v_o     (req_resp_v_o),
    .req_resp_ready_i (req_resp_ready_i),
    .cmd_o            (cmd_o),
    .cmd_v_o          (cmd_v_o),
    .cmd_yumi_i       (cmd_yumi_i),
    .resp_i           (resp_i),
    .resp_v_i         (resp_v_i),
    .resp_ready_o     (resp_ready_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference state: issuers of outstanding commands in order, rr pointer, requester holds.
  int          owner_q[$];
  int          rr = 0;
  bit   [N-1:0] pend = '0;
  logic [CW-1:0] pay [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_req();
    req_cmd_v_i = pend;
    for (int i = 0; i < N; i++) req_cmd_i[i*CW +: CW] = pay[i];
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cmd_v"},   32'(cmd_v_o),        32'd0);
    check({tag, "_yumi"},    32'(req_cmd_yumi_o), 32'd0);
    check({tag, "_resp_v"},  32'(req_resp_v_o),   32'd0);
    check({tag, "_resp_rdy"},32'(resp_ready_o),   32'd0);
  endtask

  // One clock of traffic: raise new requests, optionally let the CLINT take/answer, check, advance model.
  task automatic step(input logic [N-1:0] raise, input bit want_yumi, input bit want_resp,
                      input logic [N-1:0] rdy);
    int win, own;
    bit exp_v, yumi, own_v, rv, consumed;
    @(negedge clk_i);
    for (int i = 0; i < N; i++)
      if (raise[i] && !pend[i]) begin
        pend[i] = 1'b1;
        pay[i]  = CW'($urandom);
      end
    drive_req();
    win = -1;
    for (int k = 0; k < N; k++)
      if (win < 0 && pend[(rr + k) % N]) win = (rr + k) % N;
    exp_v = (win >= 0) && (owner_q.size() < ELS);
    yumi  = want_yumi && exp_v;
    own_v = (owner_q.size() > 0) || yumi;
    own   = (owner_q.size() > 0) ? owner_q[0] : win;
    rv    = want_resp && own_v;
    cmd_yumi_i       = yumi;
    resp_v_i         = rv;
    resp_i           = RW'($urandom);
    req_resp_ready_i = rdy;
    #1;
    check("cmd_v", 32'(cmd_v_o), 32'(exp_v));
    if (exp_v) check("cmd_o", 32'(cmd_o), 32'(pay[win]));
    check("cmd_yumi", 32'(req_cmd_yumi_o), yumi ? 32'(1 << win) : 32'd0);
    check("resp_v", 32'(req_resp_v_o), rv ? 32'(1 << own) : 32'd0);
    check("resp_ready", 32'(resp_ready_o), own_v ? 32'(rdy[own]) : 32'd0);
    if (rv) check("resp_data", 32'(req_resp_o), 32'(resp_i));
    consumed = rv && rdy[own];
    @(posedge clk_i);
    if (yumi) begin
      pend[win] = 1'b0;
      rr = (win + 1) % N;
    end
    if (owner_q.size() == 0) begin
      if (yumi && !consumed) owner_q.push_back(win);
    end else begin
      if (consumed) void'(owner_q.pop_front());
      if (yumi) owner_q.push_back(win);
    end
  endtask

  task automatic model_reset();
    owner_q.delete();
    rr   = 0;
    pend = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) pay[i] = CW'(8'h10 + i);
    reset_n_i        = 1'b0;
    cmd_yumi_i       = 1'b0;
    resp_v_i         = 1'b1;
    resp_i           = '0;
    req_resp_ready_i = '1;
    pend             = '1;
    drive_req();
    repeat (2) @(negedge clk_i);
    check_idle("rst");
    resp_v_i  = 1'b0;
    reset_n_i = 1'b1;

    // Release with both requesting: requester 0 wins first, then alternation.
    repeat (4) step(2'b11, 1'b1, 1'b1, 2'b11);

    // CLINT withholds responses until the tag FIFO fills, then drains in order.
    repeat (2) step(2'b11, 1'b1, 1'b0, 2'b11);
    step(2'b11, 1'b1, 1'b0, 2'b11);
    step(2'b11, 1'b1, 1'b1, 2'b11);
    step(2'b00, 1'b0, 1'b1, 2'b11);
    step(2'b00, 1'b0, 1'b1, 2'b11);
    repeat (2) step(2'b00, 1'b1, 1'b1, 2'b11);

    // Owner 1 stalls its response for four cycles.
    step(2'b10, 1'b1, 1'b0, 2'b11);
    repeat (4) step(2'b00, 1'b0, 1'b1, 2'b01);
    step(2'b00, 1'b0, 1'b1, 2'b11);

    // Same-cycle answer with nothing outstanding; nothing must remain afterwards.
    step(2'b10, 1'b1, 1'b1, 2'b11);
    step(2'b00, 1'b0, 1'b1, 2'b11);

    // Reset with two commands in flight.
    repeat (2) step(2'b11, 1'b1, 1'b0, 2'b11);
    @(negedge clk_i);
    reset_n_i = 1'b0;
    #1;
    check_idle("midrst");
    model_reset();
    drive_req();
    cmd_yumi_i = 1'b0;
    resp_v_i   = 1'b0;
    @(negedge clk_i);
    reset_n_i = 1'b1;
    step(2'b11, 1'b1, 1'b1, 2'b11);

    for (int n = 0; n < 500; n++)
      step(N'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
           N'($urandom) | N'($urandom));
    repeat (6) step(2'b00, 1'b1, 1'b1, 2'b11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
